// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter.
// Holds FSM states, grant encoding and the priority pick.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_D
  } grant_t;

  localparam logic [3:0] BE_WORD = 4'hF;

  // Data wins unless a pending fetch has been starved long enough.
  function automatic grant_t arb_pick(
    input logic if_req,
    input logic d_req,
    input logic starved
  );
    grant_t g;
    g = GNT_NONE;
    if (d_req && !(if_req && starved)) g = GNT_D;
    else if (if_req) g = GNT_IF;
    return g;
  endfunction

  // Expands a byte-enable mask to a 32-bit lane mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM data accesses onto one memory port.
// Fixed-latency IDLE/BUSY/RESP sequencing with registered responses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic [3:0]  d_rd,
  input  logic [3:0]  d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t     state, state_n;
  grant_t         gnt, pick;
  logic [CW-1:0]  cnt, cnt_n;
  logic [SW-1:0]  starve_cnt, starve_n;
  logic           d_req, starved, load, capture;
  logic [31:0]    a_addr, a_wdata;
  logic [3:0]     a_be;
  logic           a_we;
  logic [31:0]    if_rdata_q, d_rdata_q;
  logic           unused_addr;

  assign d_req   = (|d_rd) | (|d_wr);
  assign starved = (starve_cnt == SW'(STARVE_MAX));
  assign pick    = arb_pick(if_req, d_req, starved);

  // Next-state, latency counter and starvation bookkeeping.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    starve_n = starve_cnt;
    load     = 1'b0;
    capture  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (if_req || d_req) begin
          load    = 1'b1;
          state_n = ST_BUSY;
          cnt_n   = CW'(MEM_LAT - 1);
          if (pick == GNT_IF || !if_req) starve_n = '0;
          else starve_n = starve_cnt + SW'(1);
        end
      end
      ST_BUSY: begin
        if (cnt == '0) begin
          capture = 1'b1;
          state_n = ST_RESP;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State, counter and starvation registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      starve_cnt <= starve_n;
    end
  end

  // Latch the winning request so the memory sees stable fields.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt     <= GNT_NONE;
      a_addr  <= '0;
      a_be    <= '0;
      a_we    <= 1'b0;
      a_wdata <= '0;
    end else if (load) begin
      gnt <= pick;
      if (pick == GNT_IF) begin
        a_addr  <= {if_addr[31:2], 2'b00};
        a_be    <= BE_WORD;
        a_we    <= 1'b0;
        a_wdata <= '0;
      end else begin
        a_addr  <= {d_addr[31:2], 2'b00};
        a_we    <= |d_wr;
        a_be    <= (|d_wr) ? d_wr : d_rd;
        a_wdata <= d_wdata;
      end
    end
  end

  // Capture read data on the last busy cycle; writes return zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (capture) begin
      if (gnt == GNT_IF) if_rdata_q <= mem_rdata;
      else d_rdata_q <= a_we ? '0 : (mem_rdata & lane_mask(a_be));
    end
  end

  assign mem_en    = (state == ST_BUSY);
  assign mem_we    = mem_en & a_we;
  assign mem_be    = mem_en ? a_be : '0;
  assign mem_addr  = mem_en ? a_addr : '0;
  assign mem_wdata = mem_we ? a_wdata : '0;

  assign if_ack   = (state == ST_RESP) && (gnt == GNT_IF);
  assign d_ack    = (state == ST_RESP) && (gnt == GNT_D);
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

  assign unused_addr = ^{if_addr[1:0], d_addr[1:0]};

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares the pipeline's single-ported unified memory between the IF-stage instruction fetch and the MEM-stage data access. It serialises the two requesters and runs a fixed-latency memory access through an IDLE/BUSY/RESP state machine. It returns a registered response and drives per-stage stall signals to hold the pipeline. Byte masks on the data port match the datapath's 4-bit MemRead/MemWrite encoding.

## Interface
- MEM_LAT, 2: memory access cycles per transaction, ≥1
- STARVE_MAX, 3: consecutive data grants allowed while a fetch is pending; ≥1
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched word, valid when if_ack
- if_ack  out  1  one-cycle completion pulse
- d_rd  in  4  data read byte mask (MemRead)
- d_wr  in  4  data write byte mask (MemWrite)
- d_addr  in  32  data byte address
- d_wdata  in  32  write data, lane-aligned
- d_rdata  out  32  read data, disabled lanes zero, valid when d_ack
- d_ack  out  1  one-cycle completion pulse
- stall_if  out  1  hold IF stage
- stall_mem  out  1  hold MEM stage and everything upstream
- mem_en  out  1  memory access active
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wdata  out  32  write data
- mem_rdata  in  32  memory read data

## Operation
- d_req = |d_rd | |d_wr.
- **IDLE**
  - If any request is present, arbitrate, latch grant/address/mask/wdata into registers, and go to BUSY with cnt = MEM_LAT-1.
  - Otherwise stay in IDLE.
- **Arbitration**
  - Data wins over fetch.
  - Exception: fetch wins if starve_cnt == STARVE_MAX.
  - starve_cnt increments on each data grant while if_req=1.
  - starve_cnt clears on a fetch grant, or when arbitrating with if_req=0.
- **BUSY**
  - Drive mem_en=1 and the mem_* fields from the registers, held stable.
  - Decrement cnt each cycle.
  - At cnt==0: capture mem_rdata masked by the latched be, then go to RESP.
- **RESP**
  - Pulse the granted ack for exactly one cycle, with rdata from the capture register.
  - Ignore requests this cycle; go to IDLE.
- **Access types**
  - Fetch: be=4'hF, we=0.
  - Data write (d_wr≠0): we=1, be=d_wr; the response has d_rdata=0.
  - d_rd and d_wr both nonzero: treated as a write, d_rd ignored.
  - Data read: we=0, be=d_rd.
- **Stalls (combinational)**
  - stall_if = if_req & ~if_ack.
  - stall_mem = d_req & ~d_ack.
- **Request dropped mid-access:** the access completes and the ack still pulses; the requester ignores it.
- **Misalignment:** addr[1:0] is ignored; lane placement is the datapath's job.

## Timing
- Request seen in IDLE at cycle 0 → BUSY cycles 1..MEM_LAT → ack at cycle MEM_LAT+1.
- Back-to-back transactions cost MEM_LAT+2 cycles each; there is one IDLE bubble after every RESP.
- Reset values:
  - State is IDLE; cnt and starve_cnt are 0.
  - All outputs are 0, including rdata registers and acks.
  - Stalls follow their combinational equations.
- Reset mid-access aborts the transaction: mem_en falls immediately (async) and no ack is issued. Requests still held at release re-arbitrate from IDLE.
- A MEM_LAT=1 build has a single BUSY cycle.

## Structure
- Package mem_arb_pkg holds:
  - typedef enum arb_state_t {ST_IDLE, ST_BUSY, ST_RESP}
  - typedef enum grant_t {GNT_NONE, GNT_IF, GNT_D}
  - localparam BE_WORD = 4'hF
- Single module; no sub-module. The priority pick is a small combinational function in the package.

## Test plan
- Fetch alone, if_addr=0x10, mem_rdata=0xDEADBEEF:
  - mem_en=1 with mem_addr 0x10, be 4'hF in cycles 1–2.
  - if_ack with if_rdata=0xDEADBEEF in cycle 3.
  - stall_if=1 in cycles 0–2.
- if_req and d_rd=4'hF (d_addr 0x100) in the same cycle:
  - d_ack in cycle 3.
  - Fetch granted in cycle 4, if_ack in cycle 7.
  - stall_if high throughout cycles 0–6.
- Byte store d_wr=4'b0010, d_addr=0x203, d_wdata=0x0000AB00:
  - mem_addr=0x200, mem_we=1, mem_be=4'b0010, mem_wdata=0x0000AB00.
  - d_ack in cycle 3 with d_rdata=0.
- Continuous data reads with if_req held:
  - Exactly 3 data grants, then a fetch grant.
  - starve_cnt is 0 after the fetch grant.
- Halfword read d_rd=4'b1100, mem_rdata=0x12345678: d_rdata=0x12340000.
- Reset asserted in BUSY cycle 1 of a write:
  - mem_en and mem_we drop the same cycle; no d_ack.
  - After release, the held request completes normally with d_ack MEM_LAT+1 cycles later.
